image_job_scheduler: RTL and testbench

- Sequences the image processing engine: arbitrates processing jobs from up to NUM_REQ requesters and launches one job at a time.
- Per job: drives the engine opcode, issues the engine restart, waits for the engine done flag, drains the image writer, then reports completion to the winning requester.
- Sits between the host/command logic and the image read/process engine and its image writer.

---
 rtl/image_job_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_image_job_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_job_scheduler.sv
// Round-robin job launcher for the image engine: grants one requester, pulses the
// engine reset, waits for done, lets the writer drain, then reports completion.
module image_job_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int RST_CYCLES   = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int TIMEOUT      = 2000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_opcode,
  output logic                 eng_rst_n,
  output logic [1:0]           eng_opcode,
  input  logic                 eng_done,
  input  logic                 wr_idle,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic [NUM_REQ-1:0]   job_done,
  output logic                 job_err
);

  localparam int RUN_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LCH_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [LCH_W-1:0] LCH_LAST = LCH_W'(RST_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = (FLUSH_CYCLES > 0) ? FL_W'(FLUSH_CYCLES - 1) : '0;
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic [1:0]       OP_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_FLUSH,
    S_REPORT
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_eng_rst_n, w_eng_rst_n_next;
  logic [1:0]         r_eng_opcode, w_eng_opcode_next;
  logic [ID_W-1:0]    r_grant_id, w_grant_id_next;
  logic [ID_W-1:0]    r_rr_ptr, w_rr_ptr_next;
  logic               r_err, w_err_next;
  logic [NUM_REQ-1:0] r_job_done, w_job_done_next;
  logic               r_job_err, w_job_err_next;
  logic [LCH_W-1:0]   r_launch_cnt, w_launch_cnt_next;
  logic [RUN_W-1:0]   r_run_cnt, w_run_cnt_next;
  logic [FL_W-1:0]    r_flush_cnt, w_flush_cnt_next;

  // Requester index at each rotation offset from the round-robin pointer.
  logic [ID_W-1:0]    w_rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_rot_req;
  logic [NUM_REQ-1:0] w_grant_onehot;
  logic               w_any_req;
  logic [ID_W-1:0]    w_pick_id;
  logic [1:0]         w_pick_opcode;
  logic [ID_W-1:0]    w_rr_after;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [ID_W:0] w_sum;
      assign w_sum          = {1'b0, r_rr_ptr} + (ID_W+1)'(gi);
      assign w_rot_idx[gi]  = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                                            : ID_W'(w_sum);
      assign w_rot_req[gi]  = req[w_rot_idx[gi]];
      assign w_grant_onehot[gi] = (r_grant_id == ID_W'(gi));
    end
  endgenerate

  // Scan from the far end so the smallest offset from rr_ptr is the one kept.
  always_comb begin
    w_any_req = 1'b0;
    w_pick_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot_req[i]) begin
        w_any_req = 1'b1;
        w_pick_id = w_rot_idx[i];
      end
    end
  end

  assign w_pick_opcode = req_opcode[{w_pick_id, 1'b0} +: 2];
  assign w_rr_after    = (r_grant_id == ID_LAST) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_eng_rst_n  <= 1'b0;
      r_eng_opcode <= 2'd0;
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
      r_err        <= 1'b0;
      r_job_done   <= '0;
      r_job_err    <= 1'b0;
      r_launch_cnt <= '0;
      r_run_cnt    <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_eng_rst_n  <= w_eng_rst_n_next;
      r_eng_opcode <= w_eng_opcode_next;
      r_grant_id   <= w_grant_id_next;
      r_rr_ptr     <= w_rr_ptr_next;
      r_err        <= w_err_next;
      r_job_done   <= w_job_done_next;
      r_job_err    <= w_job_err_next;
      r_launch_cnt <= w_launch_cnt_next;
      r_run_cnt    <= w_run_cnt_next;
      r_flush_cnt  <= w_flush_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_eng_rst_n_next  = r_eng_rst_n;
    w_eng_opcode_next = r_eng_opcode;
    w_grant_id_next   = r_grant_id;
    w_rr_ptr_next     = r_rr_ptr;
    w_err_next        = r_err;
    w_job_done_next   = '0;
    w_job_err_next    = 1'b0;
    w_launch_cnt_next = r_launch_cnt;
    w_run_cnt_next    = r_run_cnt;
    w_flush_cnt_next  = r_flush_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_id_next   = w_pick_id;
          w_eng_opcode_next = w_pick_opcode;
          w_launch_cnt_next = '0;
          if (w_pick_opcode == OP_ILLEGAL) begin
            // Illegal jobs are refused without disturbing the engine.
            w_err_next   = 1'b1;
            w_state_next = S_REPORT;
          end else begin
            w_err_next       = 1'b0;
            w_eng_rst_n_next = 1'b0;
            w_state_next     = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        if (r_launch_cnt == LCH_LAST) begin
          w_eng_rst_n_next = 1'b1;
          w_run_cnt_next   = '0;
          w_state_next     = S_RUN;
        end else begin
          w_launch_cnt_next = r_launch_cnt + 1'b1;
        end
      end

      S_RUN: begin
        // A done level seen in the first two RUN cycles may be stale from the last job.
        if (eng_done && (r_run_cnt > RUN_ONE)) begin
          w_flush_cnt_next = '0;
          w_state_next     = S_FLUSH;
        end else if (r_run_cnt == RUN_LAST) begin
          w_eng_rst_n_next = 1'b0;
          w_err_next       = 1'b1;
          w_state_next     = S_REPORT;
        end else begin
          w_run_cnt_next = r_run_cnt + 1'b1;
        end
      end

      S_FLUSH: begin
        if (r_flush_cnt != FL_LAST) begin
          w_flush_cnt_next = r_flush_cnt + 1'b1;
        end else if (wr_idle) begin
          w_err_next   = 1'b0;
          w_state_next = S_REPORT;
        end
      end

      S_REPORT: begin
        w_job_done_next = w_grant_onehot;
        w_job_err_next  = r_err;
        w_rr_ptr_next   = w_rr_after;
        w_state_next    = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign eng_rst_n  = r_eng_rst_n;
  assign eng_opcode = r_eng_opcode;
  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_grant_id;
  assign job_done   = r_job_done;
  assign job_err    = r_job_err;

endmodule

// File: tb/tb_image_job_scheduler.sv
// Directed bench for image_job_scheduler: a cycle-timeline model checked every
// cycle, plus hand-computed latency and grant-order expectations.
module tb_image_job_scheduler;
  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int RST_CYCLES   = 2;
  localparam int FLUSH_CYCLES = 4;
  localparam int TIMEOUT      = 50;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [2*NUM_REQ-1:0] req_opcode = '0;
  logic                 eng_rst_n;
  logic [1:0]           eng_opcode;
  logic                 eng_done = 1'b0;
  logic                 wr_idle = 1'b1;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic [NUM_REQ-1:0]   job_done;
  logic                 job_err;

  int checks = 0;
  int errors = 0;

  image_job_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .RST_CYCLES(RST_CYCLES),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_opcode(req_opcode),
    .eng_rst_n(eng_rst_n), .eng_opcode(eng_opcode), .eng_done(eng_done),
    .wr_idle(wr_idle), .busy(busy), .grant_id(grant_id),
    .job_done(job_done), .job_err(job_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Engine stand-in: mode 0 raises done done_delay cycles after reset release,
  // mode 1 never finishes, mode 2 holds done stuck high.
  int eng_mode = 0;
  int done_delay = 10;
  int eng_hi_cnt = 0;
  int t_eng_rise = -1;
  initial forever begin
    @(negedge CLK);
    if (eng_mode == 2) begin
      eng_done = 1'b1;
    end else if (!eng_rst_n) begin
      eng_done = 1'b0;
      eng_hi_cnt = 0;
    end else begin
      if (eng_mode == 0 && eng_hi_cnt == done_delay && !eng_done) begin
        eng_done = 1'b1;
        t_eng_rise = cyc;
      end
      eng_hi_cnt++;
    end
  end

  // Observed events, timestamped in cycles.
  int t_rst_rise = -1, t_rst_fall = -1, t_jd = -1, n_rise = 0;
  logic prev_rst_n = 1'b0;
  int done_id_q[$];
  int done_err_q[$];
  initial forever begin
    @(negedge CLK);
    if (eng_rst_n && !prev_rst_n) begin
      t_rst_rise = cyc;
      n_rise++;
    end
    if (!eng_rst_n && prev_rst_n) t_rst_fall = cyc;
    prev_rst_n = eng_rst_n;
    if (job_done != '0) begin
      t_jd = cyc;
      for (int i = 0; i < NUM_REQ; i++) if (job_done[i]) done_id_q.push_back(i);
      done_err_q.push_back(int'(job_err));
    end
  end

  // Timeline model: after a grant at edge g, reset rises at g+RST_CYCLES; RUN cycle k
  // is sampled at edge g+RST_CYCLES+k+1; job_done appears one edge after the report decision.
  int e_cnt, m_rr, m_free_edge, m_run_edge, m_accept_edge, m_report_edge, m_w;
  bit m_active;
  logic m_rst_n, m_busy, m_job_err, m_err;
  logic [1:0] m_op;
  logic [ID_W-1:0] m_gid;
  logic [NUM_REQ-1:0] m_done;

  task automatic model_reset();
    e_cnt = 0; m_rr = 0; m_free_edge = 0; m_run_edge = 0;
    m_accept_edge = -1; m_report_edge = -1; m_active = 0;
    m_rst_n = 0; m_busy = 0; m_job_err = 0; m_err = 0;
    m_op = 0; m_gid = 0; m_done = 0;
  endtask

  task automatic model_step();
    e_cnt++;
    m_done = '0;
    m_job_err = 1'b0;
    if (!m_active) begin
      if (e_cnt >= m_free_edge && req != '0) begin
        m_w = -1;
        for (int i = 0; i < NUM_REQ; i++)
          if (m_w < 0 && req[(m_rr + i) % NUM_REQ]) m_w = (m_rr + i) % NUM_REQ;
        m_gid = ID_W'(m_w);
        m_op = req_opcode[2*m_w +: 2];
        m_active = 1;
        m_busy = 1;
        m_accept_edge = -1;
        if (m_op == 2'd3) begin
          m_err = 1;
          m_report_edge = e_cnt;
        end else begin
          m_rst_n = 0;
          m_run_edge = e_cnt + RST_CYCLES;
          m_report_edge = -1;
        end
      end
    end else if (m_report_edge >= 0) begin
      if (e_cnt == m_report_edge + 1) begin
        m_done = NUM_REQ'(1) << m_gid;
        m_job_err = m_err;
        m_busy = 0;
        m_active = 0;
        m_rr = (int'(m_gid) + 1) % NUM_REQ;
        m_free_edge = e_cnt + 1;
      end
    end else if (e_cnt == m_run_edge) begin
      m_rst_n = 1;
    end else if (e_cnt > m_run_edge) begin
      if (m_accept_edge < 0) begin
        if ((e_cnt - m_run_edge - 1) >= 2 && eng_done) begin
          m_accept_edge = e_cnt;
        end else if ((e_cnt - m_run_edge - 1) == TIMEOUT - 1) begin
          m_rst_n = 0;
          m_err = 1;
          m_report_edge = e_cnt;
        end
      end else if (e_cnt >= m_accept_edge + FLUSH_CYCLES && wr_idle) begin
        m_err = 0;
        m_report_edge = e_cnt;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge CLK);
    check("busy", busy, m_busy);
    check("eng_rst_n", eng_rst_n, m_rst_n);
    check("eng_opcode", eng_opcode, m_op);
    check("grant_id", grant_id, m_gid);
    check("job_done", job_done, m_done);
    check("job_err", job_err, m_job_err);
  end

  bit auto_drop = 1;
  task automatic tick();
    @(negedge CLK);
    #1;
    if (auto_drop) req = req & ~job_done;
  endtask

  task automatic wait_dones(input string name, input int target, input int budget);
    int n = 0;
    while (done_id_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(name, done_id_q.size() >= target, 1);
  endtask

  task automatic wait_level(input string name, input bit want_done, input int budget);
    int n = 0;
    while ((want_done ? eng_done : eng_rst_n) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, want_done ? eng_done : eng_rst_n, 1);
  endtask

  int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
  int base, t_q, t_w, rise_before;

  initial begin
    repeat (3) tick();
    check("reset_eng_rst_n", eng_rst_n, 0);
    check("reset_busy", busy, 0);
    check("reset_job_done", job_done, 0);
    RESET = 1'b1;
    repeat (2) tick();

    // Round robin with 1011 held for six jobs.
    auto_drop = 0;
    base = done_id_q.size();
    req = 4'b1011;
    wait_dones("rr_jobs", base + 6, 600);
    req = '0;
    auto_drop = 1;
    for (int i = 0; i < 6; i++)
      if (done_id_q.size() > base + i) check("rr_order", done_id_q[base + i], rr_exp[i]);
    check("rr_rst_low_cycles", t_rst_rise - t_rst_fall, 2);

    // Single job, opcode 1.
    tick();
    base = done_id_q.size();
    req_opcode = 8'h01;
    req = 4'b0001;
    t_q = cyc;
    wait_dones("single_job", base + 1, 200);
    if (done_id_q.size() > base) begin
      check("single_id", done_id_q[base], 0);
      check("single_err", done_err_q[base], 0);
    end
    check("single_req_to_rise", t_rst_rise - t_q, 1 + RST_CYCLES);
    check("single_rst_low_cycles", t_rst_rise - t_rst_fall, 2);
    check("single_done_latency", t_jd - t_eng_rise, 6);
    check("single_opcode", eng_opcode, 1);

    // Illegal opcode on requester 2.
    tick();
    base = done_id_q.size();
    rise_before = n_rise;
    req_opcode = 8'h30;
    req = 4'b0100;
    t_q = cyc;
    wait_dones("illegal_job", base + 1, 50);
    if (done_id_q.size() > base) begin
      check("illegal_id", done_id_q[base], 2);
      check("illegal_err", done_err_q[base], 1);
    end
    check("illegal_latency", t_jd - t_q, 2);
    check("illegal_no_rst_activity", n_rise, rise_before);
    check("illegal_rst_n_high", eng_rst_n, 1);

    // Timeout on requester 3.
    eng_mode = 1;
    tick();
    base = done_id_q.size();
    req_opcode = 8'h80;
    req = 4'b1000;
    wait_dones("timeout_job", base + 1, 300);
    if (done_id_q.size() > base) begin
      check("timeout_id", done_id_q[base], 3);
      check("timeout_err", done_err_q[base], 1);
    end
    check("timeout_run_cycles", t_rst_fall - t_rst_rise, TIMEOUT);
    check("timeout_report_delay", t_jd - t_rst_fall, 1);

    // Normal job after the timeout.
    eng_mode = 0;
    tick();
    base = done_id_q.size();
    req_opcode = 8'h00;
    req = 4'b0001;
    wait_dones("after_timeout_job", base + 1, 200);
    if (done_id_q.size() > base) begin
      check("after_timeout_id", done_id_q[base], 0);
      check("after_timeout_err", done_err_q[base], 0);
    end

    // Done stuck high: FLUSH entered on RUN cycle 2.
    eng_mode = 2;
    tick();
    base = done_id_q.size();
    req_opcode = 8'h08;
    req = 4'b0010;
    wait_dones("stuck_done_job", base + 1, 200);
    if (done_id_q.size() > base) check("stuck_done_id", done_id_q[base], 1);
    check("stuck_done_latency", t_jd - t_rst_rise, 3 + FLUSH_CYCLES + 1);
    eng_mode = 0;

    // Writer busy for 20 cycles after engine done.
    tick();
    base = done_id_q.size();
    wr_idle = 1'b0;
    req_opcode = 8'h10;
    req = 4'b0100;
    wait_level("wr_wait_eng_done", 1'b1, 100);
    repeat (20) tick();
    check("wr_held_no_done", done_id_q.size(), base);
    wr_idle = 1'b1;
    t_w = cyc;
    wait_dones("wr_job", base + 1, 50);
    if (done_id_q.size() > base) check("wr_id", done_id_q[base], 2);
    check("wr_release_latency", t_jd - t_w, 2);

    // Reset in the middle of RUN.
    eng_mode = 1;
    tick();
    req_opcode = 8'h00;
    req = 4'b0010;
    wait_level("midrun_wait_rise", 1'b0, 50);
    repeat (5) tick();
    base = done_id_q.size();
    #1 RESET = 1'b0;
    #1;
    check("midrun_rst_n", eng_rst_n, 0);
    check("midrun_busy", busy, 0);
    check("midrun_grant", grant_id, 0);
    check("midrun_opcode", eng_opcode, 0);
    req = '0;
    repeat (3) tick();
    check("midrun_no_done", done_id_q.size(), base);
    RESET = 1'b1;
    eng_mode = 0;
    tick();
    req_opcode = 8'h01;
    req = 4'b1001;
    wait_dones("post_reset_jobs", base + 2, 400);
    if (done_id_q.size() > base + 1) begin
      check("post_reset_first_id", done_id_q[base], 0);
      check("post_reset_second_id", done_id_q[base + 1], 3);
    end
    req = '0;

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
